// File: rtl/alphabet_pkg.sv
// alphabet_pkg: shared definitions for the status-word display path.
//   - 4-bit letter codes understood by the per-digit segment encoder
//   - message ids selected by the recorder control FSM
//   - scroller state enum
//   - word length / character lookup helpers used by the message ROM
package alphabet_pkg;

    // Letter codes; anything unlisted renders dark on the encoder.
    localparam logic [3:0] L_A     = 4'd0;
    localparam logic [3:0] L_C     = 4'd1;
    localparam logic [3:0] L_D     = 4'd2;
    localparam logic [3:0] L_E     = 4'd3;
    localparam logic [3:0] L_L     = 4'd4;
    localparam logic [3:0] L_O     = 4'd5;
    localparam logic [3:0] L_P     = 4'd6;
    localparam logic [3:0] L_R     = 4'd7;
    localparam logic [3:0] L_S     = 4'd8;
    localparam logic [3:0] L_T     = 4'd9;
    localparam logic [3:0] L_Y     = 4'd10;
    localparam logic [3:0] L_F     = 4'd11;
    localparam logic [3:0] L_BLANK = 4'd15;

    // Message ids.
    localparam logic [2:0] MSG_PLAY   = 3'd0;
    localparam logic [2:0] MSG_RECORD = 3'd1;
    localparam logic [2:0] MSG_STOP   = 3'd2;
    localparam logic [2:0] MSG_DELETE = 3'd3;
    localparam logic [2:0] MSG_CLEAR  = 3'd4;
    localparam logic [2:0] MSG_REPLAY = 3'd5;
    localparam logic [2:0] MSG_NONE6  = 3'd6;
    localparam logic [2:0] MSG_NONE7  = 3'd7;

    // Longest word and the width needed to hold its length.
    localparam int MAX_LEN = 6;
    localparam int LEN_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_SCROLL = 2'd2
    } state_t;

    // Number of letters in a word; ids without a word have length 0.
    function automatic logic [LEN_W-1:0] msg_len(input logic [2:0] id);
        logic [LEN_W-1:0] n;
        case (id)
            MSG_PLAY:   n = 3'd4;
            MSG_RECORD: n = 3'd6;
            MSG_STOP:   n = 3'd4;
            MSG_DELETE: n = 3'd6;
            MSG_CLEAR:  n = 3'd5;
            MSG_REPLAY: n = 3'd6;
            default:    n = 3'd0;
        endcase
        return n;
    endfunction

    // Letter at position idx of a word; character 0 sits in the low nibble.
    function automatic logic [3:0] msg_char(input logic [2:0] id, input logic [2:0] idx);
        logic [23:0] w;
        logic [3:0]  c;
        case (id)
            MSG_PLAY:   w = {L_BLANK, L_BLANK, L_Y, L_A, L_L, L_P};
            MSG_RECORD: w = {L_D, L_R, L_O, L_C, L_E, L_R};
            MSG_STOP:   w = {L_BLANK, L_BLANK, L_P, L_O, L_T, L_S};
            MSG_DELETE: w = {L_E, L_T, L_E, L_L, L_E, L_D};
            MSG_CLEAR:  w = {L_BLANK, L_R, L_A, L_E, L_L, L_C};
            MSG_REPLAY: w = {L_Y, L_A, L_L, L_P, L_E, L_R};
            default:    w = {6{L_BLANK}};
        endcase
        case (idx)
            3'd0:    c = w[3:0];
            3'd1:    c = w[7:4];
            3'd2:    c = w[11:8];
            3'd3:    c = w[15:12];
            3'd4:    c = w[19:16];
            3'd5:    c = w[23:20];
            default: c = L_BLANK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alphabet_scroller_if.sv
// alphabet_scroller_if: command and display bundle between the recorder
// control FSM (master) and the scroller (slave).
//   msg_sel      3        word id, meaningful only with msg_load
//   msg_load     1        single-cycle load strobe
//   alphabet_bus 4*DIGITS letter codes, digit i at [4i+3:4i], digit 0 leftmost
//   busy         1        high while scrolling
//   wrap         1        one-cycle pulse when the scroll returns to position 0
// DIGITS must match the DIGITS of the scroller this bundle is connected to.
interface alphabet_scroller_if #(
    parameter int DIGITS = 4
);
    logic [2:0]          msg_sel;
    logic                msg_load;
    logic [4*DIGITS-1:0] alphabet_bus;
    logic                busy;
    logic                wrap;

    modport master (
        output msg_sel,
        output msg_load,
        input  alphabet_bus,
        input  busy,
        input  wrap
    );

    modport slave (
        input  msg_sel,
        input  msg_load,
        output alphabet_bus,
        output busy,
        output wrap
    );
endinterface

// File: rtl/alphabet_msg_rom.sv
// alphabet_msg_rom: combinational word table.
//   id   in  3      word id
//   idx  in  IDX_W  character index within the word
//   code out 4      letter code, BLANK when idx is past the end of the word
//   len  out LEN_W  number of letters in the word (0 for ids with no word)
module alphabet_msg_rom
    import alphabet_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic [2:0]       id,
    input  logic [IDX_W-1:0] idx,
    output logic [3:0]       code,
    output logic [LEN_W-1:0] len
);

    assign len = msg_len(id);

    // Letter lookup; positions past the word's end read as blank.
    always_comb begin
        code = L_BLANK;
        if (idx >= IDX_W'(len)) begin
            code = L_BLANK;
        end else begin
            code = msg_char(id, idx[2:0]);
        end
    end

endmodule

// File: rtl/alphabet_scroller.sv
// alphabet_scroller: shows a fixed status word on DIGITS letter digits.
// Words that fit are shown left-justified and static; longer words scroll
// left through the cyclic sequence word + DIGITS blanks, one position every
// TICK_DIV cycles.
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   bus  slave side of alphabet_scroller_if (msg_sel/msg_load in,
//        alphabet_bus/busy/wrap out, all outputs registered)
module alphabet_scroller #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                clk,
    input  logic                rst,
    alphabet_scroller_if.slave  bus
);
    import alphabet_pkg::*;

    // pos + digit offset must fit before the single modulo subtraction.
    localparam int POS_W  = $clog2(MAX_LEN + 2 * DIGITS);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    state_t              state;
    state_t              next_state;
    logic [2:0]          word;
    logic [2:0]          next_word;
    logic [POS_W-1:0]    pos;
    logic [POS_W-1:0]    next_pos;
    logic [POS_W-1:0]    cur_last;
    logic [TICK_W-1:0]   tick;
    logic [TICK_W-1:0]   next_tick;
    logic [LEN_W-1:0]    sel_len;
    logic                next_wrap;
    logic [4*DIGITS-1:0] next_bus;
    logic [4*DIGITS-1:0] bus_q;
    logic                busy_q;
    logic                wrap_q;

    assign sel_len  = msg_len(bus.msg_sel);
    // Last scroll position of the current word: N-1 = len + DIGITS - 1.
    assign cur_last = POS_W'(msg_len(word)) + POS_W'(DIGITS - 1);

    // Next-state logic: a load always wins and restarts at position 0.
    always_comb begin
        next_state = state;
        next_word  = word;
        next_pos   = pos;
        next_tick  = tick;
        next_wrap  = 1'b0;
        if (bus.msg_load) begin
            next_word = bus.msg_sel;
            next_pos  = {POS_W{1'b0}};
            next_tick = {TICK_W{1'b0}};
            if (sel_len == {LEN_W{1'b0}}) begin
                next_state = ST_IDLE;
            end else if (int'(sel_len) <= DIGITS) begin
                next_state = ST_SHOW;
            end else begin
                next_state = ST_SCROLL;
            end
        end else if (state == ST_SCROLL) begin
            if (tick == TICK_LAST) begin
                next_tick = {TICK_W{1'b0}};
                if (pos == cur_last) begin
                    next_pos  = {POS_W{1'b0}};
                    next_wrap = 1'b1;
                end else begin
                    next_pos = pos + POS_W'(1);
                end
            end else begin
                next_tick = tick + TICK_W'(1);
            end
        end else begin
            next_pos  = {POS_W{1'b0}};
            next_tick = {TICK_W{1'b0}};
        end
    end

    // One ROM lookup per digit on the next window, so the registered bus
    // shows a new word in the same cycle as the new state.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [LEN_W-1:0] len;
        logic [POS_W-1:0] period;
        logic [POS_W-1:0] raw;
        logic [POS_W-1:0] idx;
        logic [3:0]       code;

        assign period = POS_W'(len) + POS_W'(DIGITS);
        assign raw    = next_pos + POS_W'(g);
        // raw < 2*period, so one subtraction is a full modulo.
        assign idx    = (raw >= period) ? (raw - period) : raw;

        alphabet_msg_rom #(
            .IDX_W (POS_W)
        ) u_rom (
            .id   (next_word),
            .idx  (idx),
            .code (code),
            .len  (len)
        );

        assign next_bus[4*g +: 4] = code;
    end

    // State, scroll counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            word   <= MSG_NONE6;
            pos    <= {POS_W{1'b0}};
            tick   <= {TICK_W{1'b0}};
            bus_q  <= {(4*DIGITS){1'b1}};
            busy_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            state  <= next_state;
            word   <= next_word;
            pos    <= next_pos;
            tick   <= next_tick;
            bus_q  <= next_bus;
            busy_q <= (next_state == ST_SCROLL);
            wrap_q <= next_wrap;
        end
    end

    assign bus.alphabet_bus = bus_q;
    assign bus.busy         = busy_q;
    assign bus.wrap         = wrap_q;

endmodule

// File: tb/tb_alphabet_scroller.sv
module tb_alphabet_scroller;
    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;

    logic clk = 1'b0;
    logic rst;

    alphabet_scroller_if #(.DIGITS(DIGITS)) bus_if();

    alphabet_scroller #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the word as text plus cycles elapsed since it was loaded.
    string words [8] = '{"PLAY", "RECORD", "STOP", "DELETE", "CLEAR", "REPLAY", "", ""};
    int m_id = 6;
    int m_t  = 0;

    typedef struct {
        logic        r;
        logic        ld;
        logic [2:0]  sel;
        int          hold;
        logic [15:0] bus;
        logic        busy;
        logic        wrap;
    } vec_t;

    vec_t tbl [$];

    function automatic logic [3:0] code_of(byte c);
        case (c)
            "A": return 4'd0;
            "C": return 4'd1;
            "D": return 4'd2;
            "E": return 4'd3;
            "L": return 4'd4;
            "O": return 4'd5;
            "P": return 4'd6;
            "R": return 4'd7;
            "S": return 4'd8;
            "T": return 4'd9;
            "Y": return 4'd10;
            "F": return 4'd11;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [15:0] pack4(logic [3:0] d0, logic [3:0] d1, logic [3:0] d2, logic [3:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [15:0] model_bus();
        string w = words[m_id];
        int len = w.len();
        int n = len + DIGITS;
        int p = (len > DIGITS) ? (m_t / TICK_DIV) % n : 0;
        logic [15:0] r = 16'hFFFF;
        for (int i = 0; i < DIGITS; i++) begin
            int k = (p + i) % n;
            r[4*i +: 4] = (k < len) ? code_of(w[k]) : 4'hF;
        end
        return r;
    endfunction

    function automatic logic model_busy();
        return words[m_id].len() > DIGITS;
    endfunction

    function automatic logic model_wrap();
        int n = words[m_id].len() + DIGITS;
        return model_busy() && (m_t > 0) && (m_t % TICK_DIV == 0) && ((m_t / TICK_DIV) % n == 0);
    endfunction

    function automatic vec_t mk(logic r, logic ld, logic [2:0] sel, int hold,
                                logic [15:0] b, logic busy, logic wrap);
        vec_t v;
        v.r = r; v.ld = ld; v.sel = sel; v.hold = hold;
        v.bus = b; v.busy = busy; v.wrap = wrap;
        return v;
    endfunction

    // Apply inputs for one clock edge, advance the model, sample 1 ns later.
    task automatic drive_edge(input logic r, input logic ld, input logic [2:0] sel);
        rst = r;
        bus_if.msg_load = ld;
        bus_if.msg_sel  = sel;
        @(posedge clk);
        if (r) begin
            m_id = 6;
            m_t  = 0;
        end else if (ld) begin
            m_id = int'(sel);
            m_t  = 0;
        end else begin
            m_t++;
        end
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] eb, input logic ebusy, input logic ewrap);
        vectors++;
        if (bus_if.alphabet_bus !== eb || bus_if.busy !== ebusy || bus_if.wrap !== ewrap) begin
            miscompares++;
            $display("FAIL %s: got bus=%h busy=%b wrap=%b, expected bus=%h busy=%b wrap=%b",
                     name, bus_if.alphabet_bus, bus_if.busy, bus_if.wrap, eb, ebusy, ewrap);
        end
    endtask

    task automatic check_model(input string name);
        check(name, model_bus(), model_busy(), model_wrap());
    endtask

    initial begin
        logic [15:0] rec_win [10];
        rst = 1'b1;
        bus_if.msg_load = 1'b0;
        bus_if.msg_sel  = 3'd0;

        // RECORD windows, digit0..digit3.
        rec_win[0] = pack4(7, 3, 1, 5);
        rec_win[1] = pack4(3, 1, 5, 7);
        rec_win[2] = pack4(1, 5, 7, 2);
        rec_win[3] = pack4(5, 7, 2, 15);
        rec_win[4] = pack4(7, 2, 15, 15);
        rec_win[5] = pack4(2, 15, 15, 15);
        rec_win[6] = pack4(15, 15, 15, 15);
        rec_win[7] = pack4(15, 15, 15, 7);
        rec_win[8] = pack4(15, 15, 7, 3);
        rec_win[9] = pack4(15, 7, 3, 1);

        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 2, 16'hFFFF, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 3'd0, 21, pack4(6, 4, 0, 10), 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 3'd2, 4, pack4(8, 9, 5, 6), 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 3'd1, 4, rec_win[0], 1'b1, 1'b0));
        for (int w = 1; w < 10; w++) begin
            tbl.push_back(mk(1'b0, 1'b0, 3'd1, 4, rec_win[w], 1'b1, 1'b0));
        end
        tbl.push_back(mk(1'b0, 1'b0, 3'd1, 4, rec_win[0], 1'b1, 1'b1));

        // Table-driven directed vectors; wrap is only expected on the first cycle of an entry.
        for (int i = 0; i < tbl.size(); i++) begin
            for (int h = 0; h < tbl[i].hold; h++) begin
                drive_edge(tbl[i].r, (h == 0) ? tbl[i].ld : 1'b0, tbl[i].sel);
                check($sformatf("tbl%0d.%0d", i, h), tbl[i].bus, tbl[i].busy,
                      (h == 0) ? tbl[i].wrap : 1'b0);
            end
        end

        // Load collides with the terminal tick of the last DELETE position.
        drive_edge(1'b0, 1'b1, 3'd3);
        check_model("del_load");
        for (int c = 0; c < 39; c++) begin
            drive_edge(1'b0, 1'b0, 3'd0);
            check_model("del_scroll");
        end
        check("del_last_pos", pack4(15, 2, 3, 4), 1'b1, 1'b0);
        drive_edge(1'b0, 1'b1, 3'd4);
        check("collide_load", pack4(1, 4, 3, 0), 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive_edge(1'b0, 1'b0, 3'd0);
            check("collide_hold", pack4(1, 4, 3, 0), 1'b1, 1'b0);
        end
        drive_edge(1'b0, 1'b0, 3'd0);
        check("collide_step", pack4(4, 3, 0, 7), 1'b1, 1'b0);

        // Load held high keeps reloading position 0.
        for (int c = 0; c < 8; c++) begin
            drive_edge(1'b0, 1'b1, 3'd1);
            check("held_load", pack4(7, 3, 1, 5), 1'b1, 1'b0);
        end
        for (int c = 0; c < 6; c++) begin
            drive_edge(1'b0, 1'b0, 3'd0);
            check_model("after_held");
        end

        // Blank word mid-scroll.
        drive_edge(1'b0, 1'b1, 3'd7);
        check("load_blank", 16'hFFFF, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            drive_edge(1'b0, 1'b0, 3'd0);
            check("blank_hold", 16'hFFFF, 1'b0, 1'b0);
        end

        // Reset mid-scroll, asserted together with a load: reset wins.
        drive_edge(1'b0, 1'b1, 3'd5);
        check_model("replay_load");
        for (int c = 0; c < 13; c++) begin
            drive_edge(1'b0, 1'b0, 3'd0);
            check_model("replay_scroll");
        end
        drive_edge(1'b1, 1'b1, 3'd1);
        check("rst_mid", 16'hFFFF, 1'b0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            drive_edge(1'b0, 1'b0, 3'd0);
            check("rst_still", 16'hFFFF, 1'b0, 1'b0);
        end

        // Random loads, selects and occasional resets against the model.
        for (int c = 0; c < 1200; c++) begin
            logic r;
            logic ld;
            logic [2:0] sel;
            r   = ($urandom_range(0, 99) == 0);
            ld  = ($urandom_range(0, 29) == 0);
            sel = 3'($urandom_range(0, 7));
            drive_edge(r, ld, sel);
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
